speed_switch_ctrl: RTL and testbench

SPEED_SWITCH_CTRL -- requirements
Module: speed_switch_ctrl

---
 rtl/usb4_clk_pkg.sv | 16 +
 rtl/cyc_timer.sv | 24 ++
 rtl/speed_switch_ctrl.sv | 124 ++++++++++++
 tb/tb_speed_switch_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/usb4_clk_pkg.sv
// Shared state encodings and speed codes for the link clock speed switch.
package usb4_clk_pkg;

  localparam logic [1:0] GEN_SPD_0   = 2'b00;
  localparam logic [1:0] GEN_SPD_1   = 2'b01;
  localparam logic [1:0] GEN_SPD_2   = 2'b10;
  localparam logic [1:0] GEN_SPD_BAD = 2'b11;

  localparam logic [2:0] ST_BOOT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

endpackage

// File: rtl/cyc_timer.sv
// 16-bit up-counter with clear, enable and a terminal-count compare.
// Saturates at all-ones so a long stay never wraps back into a match.
module cyc_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] tc_val,
  output logic [15:0] cnt,
  output logic        tc
);

  // Count cycles spent in the current state; cleared on every state entry.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 16'd0;
    end else if (en && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/speed_switch_ctrl.sv
// Speed switch sequencer: drains the datapath, holds the divider in reset
// while the ratio changes, waits for it to settle, then acknowledges.
//
// state  | meaning
// BOOT   | power-up divider reset, RST_CYC cycles
// IDLE   | waiting for a speed request
// DRAIN  | waiting for dp_idle, bounded by QUIESCE_MAX
// HOLD   | new ratio applied, divider held in reset RST_CYC cycles
// SETTLE | divider running, SETTLE_CYC cycles
// DONE   | one-cycle ack, back to IDLE
module speed_switch_ctrl
  import usb4_clk_pkg::*;
#(
  parameter int RST_CYC     = 4,
  parameter int SETTLE_CYC  = 64,
  parameter int QUIESCE_MAX = 1024
) (
  input  logic       local_clk,
  input  logic       rst,
  input  logic       spd_req,
  input  logic [1:0] spd_sel,
  input  logic       dp_idle,
  output logic [1:0] gen_speed,
  output logic       div_rst_n,
  output logic       spd_ack,
  output logic       spd_err,
  output logic       busy
);

  localparam logic [15:0] RST_TC     = 16'(RST_CYC - 1);
  localparam logic [15:0] SETTLE_TC  = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] QUIESCE_TC = 16'(QUIESCE_MAX - 1);

  logic [2:0]  state, nxt;
  logic [1:0]  target;
  logic        pending;
  logic [15:0] cnt;
  logic [15:0] tc_val;
  logic        tc;
  logic        imm_ack, imm_err, drain_to;

  cyc_timer u_timer (
    .clk    (local_clk),
    .rst    (rst),
    .clr    (nxt != state),
    .en     ((state != ST_IDLE) && (state != ST_DONE)),
    .tc_val (tc_val),
    .cnt    (cnt),
    .tc     (tc)
  );

  // Terminal count depends on which timed state we are in.
  always_comb begin
    tc_val = 16'd0;
    case (state)
      ST_BOOT, ST_HOLD: tc_val = RST_TC;
      ST_SETTLE:        tc_val = SETTLE_TC;
      ST_DRAIN:         tc_val = QUIESCE_TC;
      default:          tc_val = 16'd0;
    endcase
  end

  // Next-state decode plus the one-cycle ack/err triggers.
  always_comb begin
    nxt      = state;
    imm_ack  = 1'b0;
    imm_err  = 1'b0;
    drain_to = 1'b0;
    case (state)
      ST_BOOT:   if (tc) nxt = ST_SETTLE;
      ST_IDLE: begin
        if (spd_req) begin
          if (spd_sel == GEN_SPD_BAD)    imm_err = 1'b1;
          else if (spd_sel == gen_speed) imm_ack = 1'b1;
          else                           nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (dp_idle) begin
          nxt = ST_HOLD;
        end else if (tc) begin
          nxt      = ST_IDLE;
          drain_to = 1'b1;
        end
      end
      ST_HOLD:   if (tc) nxt = ST_SETTLE;
      ST_SETTLE: if (tc) nxt = pending ? ST_DONE : ST_IDLE;
      ST_DONE:   nxt = ST_IDLE;
      default:   nxt = ST_BOOT;
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state
  // so they line up with the state they belong to.
  always_ff @(posedge local_clk) begin
    if (rst) begin
      state     <= ST_BOOT;
      gen_speed <= GEN_SPD_0;
      target    <= GEN_SPD_0;
      div_rst_n <= 1'b0;
      spd_ack   <= 1'b0;
      spd_err   <= 1'b0;
      pending   <= 1'b0;
    end else begin
      state     <= nxt;
      div_rst_n <= !((nxt == ST_BOOT) || (nxt == ST_HOLD));
      spd_ack   <= imm_ack || (nxt == ST_DONE);
      spd_err   <= imm_err || drain_to;
      if ((state == ST_IDLE) && (nxt == ST_DRAIN)) begin
        target  <= spd_sel;
        pending <= 1'b1;
      end
      if ((state == ST_DRAIN) && (nxt == ST_HOLD)) begin
        gen_speed <= target;
      end
      if (drain_to || (state == ST_DONE)) begin
        pending <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_speed_switch_ctrl.sv
module tb_speed_switch_ctrl;

  logic       local_clk = 1'b0;
  logic       rst;
  logic       spd_req;
  logic [1:0] spd_sel;
  logic       dp_idle;
  logic [1:0] gen_speed;
  logic       div_rst_n;
  logic       spd_ack;
  logic       spd_err;
  logic       busy;

  int checks = 0;
  int fails  = 0;

  speed_switch_ctrl #(
    .RST_CYC     (4),
    .SETTLE_CYC  (64),
    .QUIESCE_MAX (8)
  ) dut (
    .local_clk (local_clk),
    .rst       (rst),
    .spd_req   (spd_req),
    .spd_sel   (spd_sel),
    .dp_idle   (dp_idle),
    .gen_speed (gen_speed),
    .div_rst_n (div_rst_n),
    .spd_ack   (spd_ack),
    .spd_err   (spd_err),
    .busy      (busy)
  );

  always #5 local_clk = ~local_clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge local_clk);
    #1;
  endtask

  initial begin
    int low_cnt, busy_cnt, ack_cnt, err_cnt;
    rst = 1'b1; spd_req = 1'b0; spd_sel = 2'b00; dp_idle = 1'b1;
    repeat (3) tick();
    chk("rst_div_rst_n", 16'(div_rst_n), 16'd0);
    chk("rst_busy",      16'(busy),      16'd1);
    chk("rst_gen",       16'(gen_speed), 16'd0);
    chk("rst_ack",       16'(spd_ack),   16'd0);
    chk("rst_err",       16'(spd_err),   16'd0);

    // Boot sequence: 4 cycles of divider reset, 64 of settle, then idle.
    rst = 1'b0;
    low_cnt = 0; busy_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!div_rst_n) low_cnt++;
      if (busy)       busy_cnt++;
      if (spd_ack)    ack_cnt++;
      if (i < 4) chk("boot_div_low", 16'(div_rst_n), 16'd0);
      tick();
    end
    chk("boot_low_cycles",  16'(low_cnt),  16'd4);
    chk("boot_busy_cycles", 16'(busy_cnt), 16'd68);
    chk("boot_no_ack",      16'(ack_cnt),  16'd0);
    chk("boot_gen",         16'(gen_speed), 16'd0);

    // Same-speed request: immediate ack, no divider reset.
    spd_req = 1'b1; spd_sel = 2'b00;
    tick();
    spd_req = 1'b0;
    chk("same_ack",  16'(spd_ack),   16'd1);
    chk("same_err",  16'(spd_err),   16'd0);
    chk("same_div",  16'(div_rst_n), 16'd1);
    chk("same_busy", 16'(busy),      16'd0);
    tick();
    chk("same_ack_drop", 16'(spd_ack), 16'd0);

    // Illegal speed: error pulse, nothing else moves.
    spd_req = 1'b1; spd_sel = 2'b11;
    tick();
    spd_req = 1'b0;
    chk("bad_err",  16'(spd_err),   16'd1);
    chk("bad_ack",  16'(spd_ack),   16'd0);
    chk("bad_gen",  16'(gen_speed), 16'd0);
    chk("bad_div",  16'(div_rst_n), 16'd1);
    chk("bad_busy", 16'(busy),      16'd0);
    tick();
    chk("bad_err_drop", 16'(spd_err), 16'd0);

    // Full switch to 10 with datapath idle; a stray request in SETTLE is ignored.
    spd_req = 1'b1; spd_sel = 2'b10;
    tick();
    spd_req = 1'b0;
    for (int j = 1; j <= 75; j++) begin
      chk("sw_div",  16'(div_rst_n), (j >= 2 && j <= 5) ? 16'd0 : 16'd1);
      chk("sw_gen",  16'(gen_speed), (j >= 2) ? 16'd2 : 16'd0);
      chk("sw_ack",  16'(spd_ack),   (j == 70) ? 16'd1 : 16'd0);
      chk("sw_err",  16'(spd_err),   16'd0);
      chk("sw_busy", 16'(busy),      (j <= 70) ? 16'd1 : 16'd0);
      if (j == 10) begin spd_req = 1'b1; spd_sel = 2'b01; end
      else         spd_req = 1'b0;
      tick();
    end

    // Drain timeout with QUIESCE_MAX=8; a request during DRAIN is ignored.
    dp_idle = 1'b0;
    spd_req = 1'b1; spd_sel = 2'b01;
    tick();
    spd_req = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      chk("dr_err",  16'(spd_err),   (j == 9) ? 16'd1 : 16'd0);
      chk("dr_ack",  16'(spd_ack),   16'd0);
      chk("dr_busy", 16'(busy),      (j <= 8) ? 16'd1 : 16'd0);
      chk("dr_gen",  16'(gen_speed), 16'd2);
      chk("dr_div",  16'(div_rst_n), 16'd1);
      if (j == 3) begin spd_req = 1'b1; spd_sel = 2'b00; end
      else        spd_req = 1'b0;
      tick();
    end

    // Reset pulsed during SETTLE of a switch to 01 aborts with no ack.
    dp_idle = 1'b1;
    spd_req = 1'b1; spd_sel = 2'b01;
    tick();
    spd_req = 1'b0;
    repeat (19) tick();
    chk("ab_gen_pre", 16'(gen_speed), 16'd1);
    chk("ab_div_pre", 16'(div_rst_n), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_div",  16'(div_rst_n), 16'd0);
    chk("ab_gen",  16'(gen_speed), 16'd0);
    chk("ab_busy", 16'(busy),      16'd1);
    chk("ab_ack",  16'(spd_ack),   16'd0);
    ack_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (spd_ack) ack_cnt++;
      if (spd_err) err_cnt++;
      tick();
    end
    chk("ab_no_ack",  16'(ack_cnt),   16'd0);
    chk("ab_no_err",  16'(err_cnt),   16'd0);
    chk("ab_gen_end", 16'(gen_speed), 16'd0);
    chk("ab_idle",    16'(busy),      16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
